// File: rtl/dpram_banked_arb_if.sv
// Request/response bundle for one port of the banked dual-port RAM.
// The requester drives valid/we/addr/wdata and holds them stable while stalled;
// the RAM answers with a combinational ready and a registered read-data pulse.
interface dpram_banked_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dpram_banked_arb.sv
// Banked dual-port RAM: two request ports share NUM_BANKS single-port banks.
// When both ports hit the same bank in one cycle, one of them is stalled (never
// dropped) and the cycle is counted in a saturating conflict counter. Fairness is
// either fixed (port A always wins) or round-robin via a token handed to the loser.
// Reads are two-stage: the bank is read at the accept edge into a staging register,
// which is presented with rvalid after the following edge.
module dpram_banked_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_BANKS  = 4,
    parameter int INTERLEAVE = 0,
    parameter int ARB_MODE   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dpram_banked_arb_if.slave    portA,
    dpram_banked_arb_if.slave    portB,
    output logic [CNT_WIDTH-1:0] conflict_cnt_o
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int ROWS      = 1 << ROW_BITS;

    typedef enum logic {
        TOKEN_A = 1'b0,
        TOKEN_B = 1'b1
    } token_e;

    // Bank select: high address bits for block mapping, low bits for interleave.
    function automatic logic [BANK_BITS-1:0] bankOf(input logic [ADDR_WIDTH-1:0] addr);
        if (INTERLEAVE != 0) begin
            return addr[BANK_BITS-1:0];
        end
        return addr[ADDR_WIDTH-1 -: BANK_BITS];
    endfunction

    // Row within the bank: the remaining address bits, original order kept.
    function automatic logic [ROW_BITS-1:0] rowOf(input logic [ADDR_WIDTH-1:0] addr);
        if (INTERLEAVE != 0) begin
            return addr[ADDR_WIDTH-1:BANK_BITS];
        end
        return addr[ROW_BITS-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];

    logic [BANK_BITS-1:0]  bankA;
    logic [BANK_BITS-1:0]  bankB;
    logic [ROW_BITS-1:0]   rowA;
    logic [ROW_BITS-1:0]   rowB;
    logic                  conflict;
    logic                  winB;
    logic                  readyA;
    logic                  readyB;
    logic                  acceptA;
    logic                  acceptB;

    token_e                token_q;
    token_e                token_d;
    logic [CNT_WIDTH-1:0]  conflictCnt_q;
    logic [CNT_WIDTH-1:0]  conflictCnt_d;
    logic                  rdPendA_q;
    logic                  rdPendA_d;
    logic                  rdPendB_q;
    logic                  rdPendB_d;
    logic                  rvalidA_q;
    logic                  rvalidB_q;
    logic [DATA_WIDTH-1:0] rdataA_q;
    logic [DATA_WIDTH-1:0] rdataB_q;
    logic [DATA_WIDTH-1:0] stageA_q;
    logic [DATA_WIDTH-1:0] stageB_q;

    assign bankA = bankOf(portA.addr);
    assign bankB = bankOf(portB.addr);
    assign rowA  = rowOf(portA.addr);
    assign rowB  = rowOf(portB.addr);

    // Conflict detection and arbitration; ready is forced low throughout reset.
    always_comb begin
        conflict = portA.valid && portB.valid && (bankA == bankB);
        winB     = 1'b0;
        if (conflict && (ARB_MODE != 0)) begin
            winB = (token_q == TOKEN_B);
        end
        readyA  = !rst && (!conflict || !winB);
        readyB  = !rst && (!conflict || winB);
        acceptA = portA.valid && readyA;
        acceptB = portB.valid && readyB;
    end

    // Next-state for the token, the saturating counter and the read pipeline.
    always_comb begin
        token_d       = token_q;
        conflictCnt_d = conflictCnt_q;
        if (conflict) begin
            token_d = winB ? TOKEN_A : TOKEN_B;
            if (conflictCnt_q != {CNT_WIDTH{1'b1}}) begin
                conflictCnt_d = conflictCnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
        rdPendA_d = acceptA && !portA.we;
        rdPendB_d = acceptB && !portB.we;
    end

    // Control state; reset also discards any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            token_q       <= TOKEN_A;
            conflictCnt_q <= '0;
            rdPendA_q     <= 1'b0;
            rdPendB_q     <= 1'b0;
            rvalidA_q     <= 1'b0;
            rvalidB_q     <= 1'b0;
            rdataA_q      <= '0;
            rdataB_q      <= '0;
        end else begin
            token_q       <= token_d;
            conflictCnt_q <= conflictCnt_d;
            rdPendA_q     <= rdPendA_d;
            rdPendB_q     <= rdPendB_d;
            rvalidA_q     <= rdPendA_q;
            rvalidB_q     <= rdPendB_q;
            if (rdPendA_q) begin
                rdataA_q <= stageA_q;
            end
            if (rdPendB_q) begin
                rdataB_q <= stageB_q;
            end
        end
    end

    // Bank storage: each bank sees at most one access per edge, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (acceptA) begin
            if (portA.we) begin
                mem[bankA][rowA] <= portA.wdata;
            end else begin
                stageA_q <= mem[bankA][rowA];
            end
        end
        if (acceptB) begin
            if (portB.we) begin
                mem[bankB][rowB] <= portB.wdata;
            end else begin
                stageB_q <= mem[bankB][rowB];
            end
        end
    end

    assign portA.ready    = readyA;
    assign portB.ready    = readyB;
    assign portA.rvalid   = rvalidA_q;
    assign portB.rvalid   = rvalidB_q;
    assign portA.rdata    = rdataA_q;
    assign portB.rdata    = rdataB_q;
    assign conflict_cnt_o = conflictCnt_q;
endmodule

// File: tb/tb_dpram_banked_arb.sv
// Bench for dpram_banked_arb. The main instance (block mapping, round-robin) is
// driven through a reference model of memory words, bank ownership and fairness;
// expected read data goes into per-port queues that a monitor drains whenever
// rvalid is seen. A second instance (interleaved, fixed priority) gets a short
// directed sequence.
module tb_dpram_banked_arb;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int NB    = 4;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpram_banked_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pA ();
    dpram_banked_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pB ();
    dpram_banked_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pA1 ();
    dpram_banked_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pB1 ();
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    dpram_banked_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB),
        .INTERLEAVE(0), .ARB_MODE(1), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .portA(pA), .portB(pB), .conflict_cnt_o(cnt0)
    );

    dpram_banked_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB),
        .INTERLEAVE(1), .ARB_MODE(0), .CNT_WIDTH(CW)
    ) dut1 (
        .clk(clk), .rst(rst), .portA(pA1), .portB(pB1), .conflict_cnt_o(cnt1)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    logic [DW-1:0] refMem [DEPTH];
    int            refOwnerB = 0;
    int            refCnt    = 0;
    logic [DW-1:0] expA [$];
    logic [DW-1:0] expB [$];
    logic [DW-1:0] lastA = '0;
    logic [DW-1:0] lastB = '0;

    // Outstanding requests of the bench as requester
    logic          reqAValid = 1'b0;
    logic          reqAWe    = 1'b0;
    logic [AW-1:0] reqAAddr  = '0;
    logic [DW-1:0] reqAData  = '0;
    logic          reqBValid = 1'b0;
    logic          reqBWe    = 1'b0;
    logic [AW-1:0] reqBAddr  = '0;
    logic [DW-1:0] reqBData  = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Block mapping: each bank holds one contiguous quarter of the address space.
    function automatic int bankOf0(input int addr);
        return addr / (DEPTH / NB);
    endfunction

    // One clock cycle on the main instance: drive held/new requests, check ready
    // against the model, and advance the model as the coming edge will.
    task automatic applyStimulus();
        bit conflict;
        bit winB;
        bit rdyA;
        bit rdyB;
        bit accA;
        bit accB;
        @(negedge clk);
        checkOutput("conflict_cnt", 32'(cnt0), 32'(refCnt));
        pA.valid = reqAValid; pA.we = reqAWe; pA.addr = reqAAddr; pA.wdata = reqAData;
        pB.valid = reqBValid; pB.we = reqBWe; pB.addr = reqBAddr; pB.wdata = reqBData;
        #1;
        conflict = reqAValid && reqBValid && (bankOf0(int'(reqAAddr)) == bankOf0(int'(reqBAddr)));
        winB     = conflict && (refOwnerB != 0);
        rdyA     = !conflict || !winB;
        rdyB     = !conflict || winB;
        checkOutput("a_ready", 32'(pA.ready), 32'(rdyA));
        checkOutput("b_ready", 32'(pB.ready), 32'(rdyB));
        accA = reqAValid && rdyA;
        accB = reqBValid && rdyB;
        if (accA && !reqAWe) expA.push_back(refMem[reqAAddr]);
        if (accB && !reqBWe) expB.push_back(refMem[reqBAddr]);
        if (accA && reqAWe) refMem[reqAAddr] = reqAData;
        if (accB && reqBWe) refMem[reqBAddr] = reqBData;
        if (conflict) begin
            refOwnerB = winB ? 0 : 1;
            if (refCnt < (1 << CW) - 1) refCnt++;
        end
        if (accA) reqAValid = 1'b0;
        if (accB) reqBValid = 1'b0;
    endtask

    task automatic setA(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        reqAValid = 1'b1; reqAWe = we; reqAAddr = addr; reqAData = data;
    endtask

    task automatic setB(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        reqBValid = 1'b1; reqBWe = we; reqBAddr = addr; reqBData = data;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((reqAValid || reqBValid) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("requests_drained", {30'd0, reqAValid, reqBValid}, 32'd0);
    endtask

    // Monitor: pop the expected word whenever rvalid shows; otherwise rdata must hold.
    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("a_rvalid_in_reset", 32'(pA.rvalid), 32'd0);
                checkOutput("b_rvalid_in_reset", 32'(pB.rvalid), 32'd0);
                checkOutput("a_rdata_in_reset", 32'(pA.rdata), 32'd0);
                lastA = '0;
                lastB = '0;
            end else begin
                if (pA.rvalid) begin
                    if (expA.size() == 0) begin
                        checkOutput("a_rvalid_unexpected", 32'(pA.rvalid), 32'd0);
                    end else begin
                        e = expA.pop_front();
                        checkOutput("a_rdata", 32'(pA.rdata), 32'(e));
                        lastA = e;
                    end
                end else begin
                    checkOutput("a_rdata_hold", 32'(pA.rdata), 32'(lastA));
                end
                if (pB.rvalid) begin
                    if (expB.size() == 0) begin
                        checkOutput("b_rvalid_unexpected", 32'(pB.rvalid), 32'd0);
                    end else begin
                        e = expB.pop_front();
                        checkOutput("b_rdata", 32'(pB.rdata), 32'(e));
                        lastB = e;
                    end
                end else begin
                    checkOutput("b_rdata_hold", 32'(pB.rdata), 32'(lastB));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        pA.valid = 1'b0; pA.we = 1'b0; pA.addr = '0; pA.wdata = '0;
        pB.valid = 1'b0; pB.we = 1'b0; pB.addr = '0; pB.wdata = '0;
        pA1.valid = 1'b0; pA1.we = 1'b0; pA1.addr = '0; pA1.wdata = '0;
        pB1.valid = 1'b0; pB1.we = 1'b0; pB1.addr = '0; pB1.wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_a_ready", 32'(pA.ready), 32'd0);
        checkOutput("reset_cnt", 32'(cnt0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Give every word a known value through port A alone.
        for (int i = 0; i < DEPTH; i++) begin
            setA(1'b1, AW'(i), DW'($urandom_range(0, 255)));
            waitIdle(4);
        end

        // Different banks, same cycle: both accepted, then read back together.
        setA(1'b1, 6'h00, 8'hA1); setB(1'b1, 6'h10, 8'hB2);
        waitIdle(4);
        setA(1'b0, 6'h00, 8'h00); setB(1'b0, 6'h10, 8'h00);
        waitIdle(4);
        applyStimulus();
        checkOutput("t1_conflict_cnt", 32'(cnt0), 32'd0);

        // Same bank, different rows: A wins first, B follows next cycle.
        setA(1'b1, 6'h24, 8'hCA); setB(1'b1, 6'h20, 8'hCB);
        waitIdle(4);
        setA(1'b0, 6'h24, 8'h00);
        waitIdle(4);
        setB(1'b0, 6'h20, 8'h00);
        waitIdle(4);
        applyStimulus();
        checkOutput("t2_conflict_cnt", 32'(cnt0), 32'd1);

        // Two more bank-2 conflicts: B holds the token now, then A again.
        for (int k = 0; k < 2; k++) begin
            setA(1'b1, 6'h24, 8'hCA); setB(1'b1, 6'h20, 8'hCB);
            waitIdle(4);
        end
        applyStimulus();
        checkOutput("t3_conflict_cnt", 32'(cnt0), 32'd3);

        // Write then read the same word back-to-back.
        setA(1'b1, 6'h31, 8'hD5);
        applyStimulus();
        setA(1'b0, 6'h31, 8'h00);
        waitIdle(4);
        repeat (3) applyStimulus();

        // Random traffic on both ports.
        for (int c = 0; c < 400; c++) begin
            if (!reqAValid && $urandom_range(0, 3) != 0)
                setA(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)));
            if (!reqBValid && $urandom_range(0, 3) != 0)
                setB(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 255)));
            applyStimulus();
        end
        waitIdle(8);
        repeat (3) applyStimulus();

        // Reset right after a read accept: the read must vanish, memory must stay.
        setA(1'b0, 6'h24, 8'h00);
        applyStimulus();
        @(posedge clk);
        #2;
        rst = 1'b1;
        expA.delete();
        expB.delete();
        refOwnerB = 0;
        refCnt    = 0;
        pB.valid = 1'b1; pB.we = 1'b0; pB.addr = 6'h20;
        #1;
        checkOutput("rst_a_ready", 32'(pA.ready), 32'd0);
        checkOutput("rst_b_ready", 32'(pB.ready), 32'd0);
        checkOutput("rst_conflict_cnt", 32'(cnt0), 32'd0);
        pA.valid = 1'b0;
        pB.valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        setA(1'b0, 6'h24, 8'h00); setB(1'b0, 6'h20, 8'h00);
        waitIdle(4);
        repeat (4) applyStimulus();
        checkOutput("final_a_queue_empty", 32'(expA.size()), 32'd0);
        checkOutput("final_b_queue_empty", 32'(expB.size()), 32'd0);

        // Interleaved, fixed-priority instance: A beats B on every bank-1 clash.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pA1.valid = 1'b1; pA1.we = 1'b0; pA1.addr = 6'h01;
            pB1.valid = 1'b1; pB1.we = 1'b0; pB1.addr = 6'h05;
            #1;
            checkOutput("il_a_ready", 32'(pA1.ready), 32'd1);
            checkOutput("il_b_ready", 32'(pB1.ready), 32'd0);
            @(negedge clk);
            pA1.valid = 1'b0;
            #1;
            checkOutput("il_b_ready_after", 32'(pB1.ready), 32'd1);
            checkOutput("il_conflict_cnt", 32'(cnt1), 32'(k + 1));
            @(negedge clk);
            pB1.valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        pA1.valid = 1'b1; pA1.addr = 6'h01;
        pB1.valid = 1'b1; pB1.addr = 6'h02;
        #1;
        checkOutput("il_nc_a_ready", 32'(pA1.ready), 32'd1);
        checkOutput("il_nc_b_ready", 32'(pB1.ready), 32'd1);
        @(negedge clk);
        pA1.valid = 1'b0;
        pB1.valid = 1'b0;
        checkOutput("il_rvalid_early", {30'd0, pA1.rvalid, pB1.rvalid}, 32'd0);
        @(negedge clk);
        checkOutput("il_rvalid_both", {30'd0, pA1.rvalid, pB1.rvalid}, 32'd3);
        checkOutput("il_conflict_cnt_nc", 32'(cnt1), 32'd3);
        @(negedge clk);
        checkOutput("il_rvalid_pulse", {30'd0, pA1.rvalid, pB1.rvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
